// File: rtl/osd_tracesample_arbiter.sv
// Round-robin arbiter sharing one registered trace output among N tracesample channels.
// Optional build macro OSD_TRACESAMPLE_ARB_OVPRIO_EN gives overflow records grant priority.
module osd_tracesample_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int CHW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         enable,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_overflow,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_overflow,
  output logic [CHW-1:0]       out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [N-1:0]     eligible_s;
  logic [N-1:0]     cand_s;
  logic [CHW-1:0]   grant_s;
  logic             load_s;

  logic [WIDTH-1:0] out_data_q;
  logic             out_overflow_q;
  logic [CHW-1:0]   out_chan_q;
  logic             out_valid_q;
  logic [CHW-1:0]   last_q;

  // First requester after 'last' in circular order; 'last' itself is searched last.
  function automatic logic [CHW-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [CHW-1:0] last);
    logic [CHW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        pick  = CHW'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Candidate set: overflow records first when the priority build option is present.
  always_comb begin
    eligible_s = in_valid & enable;
`ifdef OSD_TRACESAMPLE_ARB_OVPRIO_EN
    if (|(eligible_s & in_overflow)) begin
      cand_s = eligible_s & in_overflow;
    end else begin
      cand_s = eligible_s;
    end
`else
    cand_s = eligible_s;
`endif
  end

  // Grant and load decision; nothing is consumed while reset is held.
  always_comb begin
    grant_s = rr_pick(cand_s, last_q);
    load_s  = ~rst & (~out_valid_q | out_ready) & (|eligible_s);
  end

  // Disabled channels are always drained so stale samples never pile up.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        in_ready[i] = 1'b0;
      end else if (!enable[i]) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = load_s && (int'(grant_s) == i);
      end
    end
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
      out_chan_q     <= '0;
      out_valid_q    <= 1'b0;
      last_q         <= CHW'(N - 1);
    end else if (load_s) begin
      out_data_q     <= in_data[int'(grant_s)*WIDTH +: WIDTH];
      out_overflow_q <= in_overflow[grant_s];
      out_chan_q     <= grant_s;
      out_valid_q    <= 1'b1;
      last_q         <= grant_s;
    end else if (out_ready) begin
      out_valid_q    <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_q;
    end
  end

  assign out_data     = out_data_q;
  assign out_overflow = out_overflow_q;
  assign out_chan     = out_chan_q;
  assign out_valid    = out_valid_q;

endmodule
